// File: rtl/lockin_pkg.sv
// lockin_pkg: shared widths, serializer FSM states and word-select helper
package lockin_pkg;
    localparam int RESULT_W = 64;
    localparam int WORD_W   = 32;
    typedef enum logic [1:0] {EMPTY = 2'd0, FIRST = 2'd1, SECOND = 2'd2} state_t;
    function automatic logic [WORD_W-1:0] pick_word(input logic [RESULT_W-1:0] r, input logic high);
        return high ? r[RESULT_W-1:WORD_W] : r[WORD_W-1:0];
    endfunction
endpackage

// File: rtl/lockin_result_serializer_64to32.sv
// lockin_result_serializer_64to32: splits 64-bit lock-in results into 32-bit Avalon-ST words
// using a working register plus one pending slot; inputs that find no room are counted as drops.
module lockin_result_serializer_64to32
    import lockin_pkg::*;
#(
    parameter bit HIGH_FIRST = 1'b0,
    parameter int DROP_CNT_W = 16
) (
    input  logic                  wrclock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [RESULT_W-1:0]   in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WORD_W-1:0]     src_data,
    output logic                  src_valid,
    input  logic                  src_ready,
    output logic                  busy,
    output logic [DROP_CNT_W-1:0] drop_count
);
    state_t                state_q, state_d;
    logic [RESULT_W-1:0]   work_q, work_d, pend_q, pend_d;
    logic                  pend_full_q, pend_full_d;
    logic [WORD_W-1:0]     data_q, data_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;
    logic                  accept, xfer;

    // reset_n gates in_ready so the producer sees no room while reset is held
    assign in_ready   = reset_n & enable & ~pend_full_q;
    assign accept     = in_valid & in_ready;
    assign src_valid  = state_q != EMPTY;
    assign xfer       = src_valid & src_ready;
    assign src_data   = data_q;
    assign busy       = src_valid | pend_full_q;
    assign drop_count = drop_q;

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        case (state_q)
            EMPTY: if (accept) begin
                work_d  = in_data;
                state_d = FIRST;
            end
            FIRST: begin
                if (accept) begin
                    pend_d      = in_data;
                    pend_full_d = 1'b1;
                end
                if (xfer) state_d = SECOND;
            end
            SECOND: if (xfer) begin
                if (pend_full_q) begin
                    work_d      = pend_q;
                    pend_full_d = 1'b0;
                    state_d     = FIRST;
                end else if (accept) begin
                    work_d  = in_data;
                    state_d = FIRST;
                end else begin
                    state_d = EMPTY;
                end
            end else if (accept) begin
                pend_d      = in_data;
                pend_full_d = 1'b1;
            end
            default: state_d = EMPTY;
        endcase
        // output word is registered from the next WORK so src_data never glitches on inputs
        data_d = (state_d == FIRST)  ? pick_word(work_d, HIGH_FIRST) :
                 (state_d == SECOND) ? pick_word(work_d, !HIGH_FIRST) : data_q;
        drop_d = (in_valid & ~in_ready & ~&drop_q) ? drop_q + DROP_CNT_W'(1) : drop_q;
    end

    always_ff @(posedge wrclock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= EMPTY;
            work_q      <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            data_q      <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            data_q      <= data_d;
            drop_q      <= drop_d;
        end
    end
endmodule

// File: tb/tb_lockin_result_serializer_64to32.sv
// tb_lockin_result_serializer_64to32: directed and random stimulus against a word-queue model,
// driving a low-first 4-bit-counter instance and a high-first 16-bit-counter instance in parallel.
module tb_lockin_result_serializer_64to32;
    logic        clk = 1'b0;
    logic        reset_n, enable, in_valid, src_ready;
    logic [63:0] in_data;
    logic        in_ready0, src_valid0, busy0, in_ready1, src_valid1, busy1;
    logic [31:0] src_data0, src_data1;
    logic [3:0]  drop0;
    logic [15:0] drop1;
    logic [31:0] q0[$], q1[$];
    int          drops = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    lockin_result_serializer_64to32 #(.HIGH_FIRST(1'b0), .DROP_CNT_W(4)) dut0 (
        .wrclock(clk), .reset_n(reset_n), .enable(enable), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready0), .src_data(src_data0),
        .src_valid(src_valid0), .src_ready(src_ready), .busy(busy0), .drop_count(drop0));

    lockin_result_serializer_64to32 #(.HIGH_FIRST(1'b1), .DROP_CNT_W(16)) dut1 (
        .wrclock(clk), .reset_n(reset_n), .enable(enable), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready1), .src_data(src_data1),
        .src_valid(src_valid1), .src_ready(src_ready), .busy(busy1), .drop_count(drop1));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: checks outputs against the model, then advances the model across the edge.
    // Room exists while fewer than two unfinished pairs are held.
    task automatic step(input logic en, input logic iv, input logic [63:0] d, input logic sr);
        bit rdy;
        enable = en; in_valid = iv; in_data = d; src_ready = sr;
        #1;
        rdy = en && ((q0.size() + 1) / 2 < 2);
        check("in_ready0", in_ready0, rdy);
        check("in_ready1", in_ready1, rdy);
        check("src_valid0", src_valid0, q0.size() > 0);
        check("src_valid1", src_valid1, q1.size() > 0);
        if (q0.size() > 0) check("src_data0", src_data0, q0[0]);
        if (q1.size() > 0) check("src_data1", src_data1, q1[0]);
        check("busy0", busy0, q0.size() > 0);
        check("busy1", busy1, q1.size() > 0);
        check("drop0", drop0, drops > 15 ? 15 : drops);
        check("drop1", drop1, drops > 65535 ? 65535 : drops);
        @(posedge clk);
        if (q0.size() > 0 && sr) begin
            void'(q0.pop_front());
            void'(q1.pop_front());
        end
        if (iv && rdy) begin
            q0.push_back(d[31:0]);  q0.push_back(d[63:32]);
            q1.push_back(d[63:32]); q1.push_back(d[31:0]);
        end else if (iv) begin
            drops++;
        end
        #1;
    endtask

    task automatic do_reset();
        enable = 1'b1; in_valid = 1'b0; src_ready = 1'b1;
        reset_n = 1'b0;
        #1;
        check("rst_valid0", src_valid0, 1'b0);
        check("rst_valid1", src_valid1, 1'b0);
        check("rst_busy0", busy0, 1'b0);
        check("rst_ready0", in_ready0, 1'b0);
        check("rst_ready1", in_ready1, 1'b0);
        check("rst_data0", src_data0, 32'h0);
        check("rst_data1", src_data1, 32'h0);
        check("rst_drop0", drop0, 4'h0);
        check("rst_drop1", drop1, 16'h0);
        q0.delete(); q1.delete(); drops = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; in_valid = 1'b0; in_data = '0; src_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        // single result, words on consecutive cycles
        step(1, 1, 64'h11112222_33334444, 1);
        check("first_word0", src_data0, 32'h33334444);
        check("first_word1", src_data1, 32'h11112222);
        repeat (3) step(1, 0, 64'h0, 1);
        // back-to-back A, B, C: C dropped
        step(1, 1, 64'hAAAA0001_AAAA0000, 1);
        step(1, 1, 64'hBBBB0001_BBBB0000, 1);
        step(1, 1, 64'hCCCC0001_CCCC0000, 1);
        repeat (5) step(1, 0, 64'h0, 1);
        // stall mid-pair, input held in PEND, further input dropped
        step(1, 1, 64'hD0D0D0D1_D0D0D0D0, 1);
        step(1, 0, 64'h0, 1);
        step(1, 1, 64'hE0E0E0E1_E0E0E0E0, 0);
        step(1, 1, 64'hF0F0F0F1_F0F0F0F0, 0);
        repeat (3) step(1, 0, 64'h0, 0);
        repeat (5) step(1, 0, 64'h0, 1);
        // reset while in SECOND with pending result
        step(1, 1, 64'h12345678_9ABCDEF0, 1);
        step(1, 1, 64'h0FEDCBA9_87654321, 1);
        do_reset();
        step(1, 1, {32'hA, 32'hB}, 1);
        check("post_rst0", src_data0, 32'h0000000B);
        repeat (3) step(1, 0, 64'h0, 1);
        // enable low counts drops while the current pair completes; 4-bit counter saturates
        step(1, 1, 64'h55556666_77778888, 0);
        step(0, 1, 64'h99999999_99999999, 0);
        repeat (19) step(0, 1, {$urandom, $urandom}, 1);
        check("sat0", drop0, 4'hF);
        check("cnt1", drop1, 16'd20);
        repeat (3) step(1, 0, 64'h0, 1);
        do_reset();
        for (int i = 0; i < 400; i++)
            step($urandom_range(7) != 0, $urandom_range(1) != 0, {$urandom, $urandom}, $urandom_range(3) != 0);
        repeat (6) step(1, 0, 64'h0, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/lockin_result_serializer_64to32.md
LOCKIN_RESULT_SERIALIZER_64TO32 -- requirements
Module: lockin_result_serializer_64to32

Interface
REQ-001 SHALL have parameter HIGH_FIRST, default 0, meaning word order: 0 sends low word first, 1 sends high word first.
REQ-002 SHALL have parameter DROP_CNT_W, default 16, meaning the width of the drop counter.
REQ-003 SHALL use one clock and an asynchronous active-low reset, as already decided.
REQ-004 wrclock  in  1  sole clock; all state on its rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 enable  in  1  accept new 64-bit results while high.
REQ-007 in_data  in  64  lock-in result; X accumulator in [31:0], Y in [63:32].
REQ-008 in_valid  in  1  in_data valid this cycle; the producer cannot stall.
REQ-009 in_ready  out  1  the block can accept in_data this cycle.
REQ-010 src_data  out  32  Avalon-ST source data to the downstream 32-bit FIFO sink.
REQ-011 src_valid  out  1  src_data valid.
REQ-012 src_ready  in  1  downstream ready, ready latency 0.
REQ-013 busy  out  1  the working register or the pending register is occupied.
REQ-014 drop_count  out  DROP_CNT_W  number of in_valid cycles lost; saturating.

Function
REQ-015 Storage SHALL be one 64-bit working register (WORK) plus one 64-bit pending register (PEND) with flag pend_full.
REQ-016 FSM SHALL have states EMPTY, FIRST and SECOND; FIRST drives the first word of WORK and SECOND drives the second word.
REQ-017 src_valid SHALL be high exactly in FIRST and SECOND, and src_data SHALL be driven from registers only.
REQ-018 With HIGH_FIRST=0, FIRST SHALL output WORK[31:0] and SECOND SHALL output WORK[63:32]; HIGH_FIRST=1 swaps the two.
REQ-019 A word transfer SHALL occur on src_valid & src_ready; while src_ready is low, src_data and src_valid SHALL be held stable.
REQ-020 in_ready SHALL equal enable & ~pend_full.
REQ-021 An input SHALL be accepted on in_valid & in_ready.
REQ-022 An accepted input in EMPTY SHALL be loaded into WORK, and the FSM SHALL go to FIRST; latency from in_valid to src_valid is 1 cycle.
REQ-023 An accepted input in FIRST SHALL be loaded into PEND, and pend_full SHALL be set.
REQ-024 An accepted input in SECOND SHALL be loaded into PEND and set pend_full, except as given in REQ-027.
REQ-025 A transfer in FIRST SHALL move the FSM to SECOND.
REQ-026 A transfer in SECOND with pend_full set SHALL load PEND into WORK, clear pend_full and go to FIRST, with no bubble cycle.
REQ-027 A transfer in SECOND with pend_full clear and a simultaneous accept SHALL load the input directly into WORK and go to FIRST.
REQ-028 A transfer in SECOND with pend_full clear and no accept SHALL go to EMPTY.
REQ-029 In the SECOND-transfer cycle, an accept and a PEND-to-WORK move SHALL NOT coincide, because in_ready is low while pend_full is set.
REQ-030 in_valid & ~in_ready SHALL increment drop_count by 1, holding at 2^DROP_CNT_W-1; the dropped data is discarded.
REQ-031 Deasserting enable SHALL NOT abort a word pair in progress; WORK and PEND SHALL drain normally.
REQ-032 in_valid while enable is low SHALL count as a drop.
REQ-033 busy SHALL equal (state != EMPTY) | pend_full.
REQ-034 Word pairs SHALL never be split, reordered or interleaved.

Reset
REQ-035 reset_n low SHALL asynchronously force state EMPTY, pend_full 0, src_valid 0, in_ready 0, busy 0 and drop_count 0; src_data SHALL be 0.
REQ-036 Reset asserted mid-pair SHALL discard WORK and PEND; after release, the first transfer SHALL be the first word of a new pair.
REQ-037 Outputs SHALL follow normal rules from the first rising wrclock edge after reset_n is released.

Structure
REQ-038 A shared package lockin_pkg SHALL hold the FSM state typedef (EMPTY, FIRST, SECOND) and the constants RESULT_W=64 and WORD_W=32.
REQ-039 The block SHALL be a single module with no sub-modules; the drop counter is inline saturating logic.

Verification
REQ-040 Reset, enable=1, src_ready=1, a single in_data=0x11112222_33334444 -> src_valid rises next cycle; words 0x33334444 then 0x11112222 on consecutive cycles; then EMPTY and busy=0.
REQ-041 HIGH_FIRST=1, same input -> 0x11112222 first, then 0x33334444.
REQ-042 Back-to-back inputs A, B, C on consecutive cycles with src_ready=1 -> C dropped (drop_count=1); A.lo, A.hi, B.lo, B.hi with no bubble.
REQ-043 src_ready held low for 5 cycles mid-pair -> src_data stable throughout; in_valid during the stall -> held in PEND; a further input -> drop_count increments.
REQ-044 reset_n pulsed low while in SECOND with pend_full=1 -> outputs clear immediately; next input 0xA_B yields 0x0000000B then 0x0000000A.
REQ-045 DROP_CNT_W=4 with 20 dropped cycles -> drop_count saturates at 15; enable=0 with in_valid=1 counts as a drop while the current pair completes.
